iexu_multicycle: RTL

Multi-cycle integer execution unit that consumes the `iexu_conf` operation code issued by decode and returns a result with a tagged destination register. It sits between the decode/issue stage and writeback, and is the responder side of the issue handshake. Add, sub, and logic ops complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter, so a valid/ready handshake on both ends is mandatory.

---
 rtl/iexu_multicycle_pkg.sv | 35 +++
 rtl/iexu_multicycle_if.sv | 29 ++
 rtl/iexu_serial_shifter.sv | 73 +++++++
 rtl/iexu_multicycle.sv | 123 ++++++++++++
 4 files changed

// File: rtl/iexu_multicycle_pkg.sv
// Shared constants for the multi-cycle integer execution unit.
// Build option IEXU_FAST_SHIFT_EN selects the single-cycle barrel shifter.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif

package iexu_multicycle_pkg;

   typedef enum logic [2:0] {
      IEXU_ADD = 3'd0,
      IEXU_SUB = 3'd1,
      IEXU_AND = 3'd2,
      IEXU_OR  = 3'd3,
      IEXU_XOR = 3'd4,
      IEXU_SLL = 3'd5,
      IEXU_SRL = 3'd6,
      IEXU_SRA = 3'd7
   } iexu_conf;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } iexu_state;

   localparam int SHAMT_W = 5;

   function automatic logic is_shift_op(iexu_conf c);
      return (c == IEXU_SLL) || (c == IEXU_SRL) || (c == IEXU_SRA);
   endfunction

endpackage

// File: rtl/iexu_multicycle_if.sv
// Issue/writeback handshake bundle of the execution unit.
// slave = execution unit side, master = decode/writeback side.
interface iexu_multicycle_if #(
   parameter int DW = `DATA_SIZE,
   parameter int RW = `REGFILE_LOGSIZE
);
   import iexu_multicycle_pkg::*;

   logic          in_valid;
   logic          in_ready;
   iexu_conf      in_conf;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic [RW-1:0] in_rd;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic [RW-1:0] out_rd;

   modport master (
      output in_valid, in_conf, in_a, in_b, in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_rd
   );

   modport slave (
      input  in_valid, in_conf, in_a, in_b, in_rd, out_ready,
      output in_ready, out_valid, out_result, out_rd
   );
endinterface

// File: rtl/iexu_serial_shifter.sv
// One-bit-per-cycle shifter with working register and counter.
// With IEXU_FAST_SHIFT_EN it collapses to a combinational barrel shift.
module iexu_serial_shifter
   import iexu_multicycle_pkg::*;
#(
   parameter int DW = `DATA_SIZE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_kill,
   input  logic               i_load,
   input  iexu_conf           i_conf,
   input  logic [DW-1:0]      i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   output logic               o_busy,
   output logic               o_last,
   output logic [DW-1:0]      o_next
);

`ifdef IEXU_FAST_SHIFT_EN

   logic w_unused;
   assign w_unused = ^{clk, rst, i_kill, i_load};

   always_comb begin
      o_next = i_data >> i_shamt;
      if (i_conf == IEXU_SLL)
         o_next = i_data << i_shamt;
      else if (i_conf == IEXU_SRA)
         o_next = DW'($signed(i_data) >>> i_shamt);
   end

   assign o_busy = 1'b0;
   assign o_last = 1'b1;

`else

   logic [DW-1:0]      r_work;
   logic [SHAMT_W-1:0] r_cnt;
   logic               r_left;
   logic               r_arith;
   logic [DW-1:0]      w_step;

   // right shifts fill with the MSB only for the arithmetic variant
   assign w_step = r_left ? {r_work[DW-2:0], 1'b0}
                          : {r_arith & r_work[DW-1], r_work[DW-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_work  <= '0;
         r_cnt   <= '0;
         r_left  <= 1'b0;
         r_arith <= 1'b0;
      end else if (i_kill) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_work  <= i_data;
         r_cnt   <= i_shamt;
         r_left  <= (i_conf == IEXU_SLL);
         r_arith <= (i_conf == IEXU_SRA);
      end else if (r_cnt != '0) begin
         r_work <= w_step;
         r_cnt  <= r_cnt - 1'b1;
      end
   end

   assign o_busy = (r_cnt != '0);
   assign o_last = (r_cnt == SHAMT_W'(1));
   assign o_next = w_step;

`endif

endmodule

// File: rtl/iexu_multicycle.sv
// Integer execution unit: 1-cycle ALU ops, iterative shifts, registered result.
// IEXU_FAST_SHIFT_EN makes shifts single-cycle as well.
module iexu_multicycle
   import iexu_multicycle_pkg::*;
#(
   parameter int DW = `DATA_SIZE,
   parameter int RW = `REGFILE_LOGSIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   iexu_multicycle_if.slave bus
);

   iexu_state     r_state;
   iexu_state     w_state_nx;
   logic [DW-1:0] r_result;
   logic [RW-1:0] r_rd;
   logic [DW-1:0] w_alu;
   logic [DW-1:0] w_res;
   logic [DW-1:0] w_sh_next;
   logic          w_in_ready;
   logic          w_acc;
   logic          w_upd;
   logic          w_ld;
   logic          w_sh_busy;
   logic          w_sh_last;
   logic          w_unused;

   assign w_unused = w_sh_busy;

   assign w_in_ready = !rst && !flush &&
      ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
   assign w_acc = bus.in_valid && w_in_ready;

   always_comb begin
      w_alu = '0;
      unique case (bus.in_conf)
         IEXU_ADD: w_alu = bus.in_a + bus.in_b;
         IEXU_SUB: w_alu = bus.in_a + ~bus.in_b + DW'(1);
         IEXU_AND: w_alu = bus.in_a & bus.in_b;
         IEXU_OR:  w_alu = bus.in_a | bus.in_b;
         IEXU_XOR: w_alu = bus.in_a ^ bus.in_b;
         default:  w_alu = '0;
      endcase
   end

   iexu_serial_shifter #(.DW(DW)) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .i_kill  (flush),
      .i_load  (w_ld),
      .i_conf  (bus.in_conf),
      .i_data  (bus.in_a),
      .i_shamt (bus.in_b[SHAMT_W-1:0]),
      .o_busy  (w_sh_busy),
      .o_last  (w_sh_last),
      .o_next  (w_sh_next)
   );

   always_comb begin
      w_state_nx = r_state;
      w_upd      = 1'b0;
      w_ld       = 1'b0;
      w_res      = w_alu;
      unique case (r_state)
         IDLE, DONE: begin
            if (w_acc) begin
               if (!is_shift_op(bus.in_conf)) begin
                  w_state_nx = DONE;
                  w_upd      = 1'b1;
               end else begin
                  w_ld = 1'b1;
`ifdef IEXU_FAST_SHIFT_EN
                  w_state_nx = DONE;
                  w_upd      = 1'b1;
                  w_res      = w_sh_next;
`else
                  if (bus.in_b[SHAMT_W-1:0] == '0) begin
                     w_state_nx = DONE;
                     w_upd      = 1'b1;
                     w_res      = bus.in_a;
                  end else begin
                     w_state_nx = SHIFT;
                  end
`endif
               end
            end else if ((r_state == DONE) && bus.out_ready) begin
               w_state_nx = IDLE;
            end
         end
         SHIFT: begin
            if (w_sh_last) begin
               w_state_nx = DONE;
               w_upd      = 1'b1;
               w_res      = w_sh_next;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // the tag is captured at accept; result only when the op completes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_rd     <= '0;
      end else begin
         r_state <= flush ? IDLE : w_state_nx;
         if (w_upd && !flush)
            r_result <= w_res;
         if (w_acc)
            r_rd <= bus.in_rd;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = (r_state == DONE);
   assign bus.out_result = r_result;
   assign bus.out_rd     = r_rd;

endmodule
